// File: rtl/fas_freq_if.sv
// FFT-frame / dominant-bin result bundle between the FFT stage
// and the frequency analyzer.
interface fas_freq_if #(
  parameter int DW = 16
);
  logic            fft_valid;
  logic [2*DW-1:0] fft_d0;
  logic [2*DW-1:0] fft_d1;
  logic [2*DW-1:0] fft_d2;
  logic [2*DW-1:0] fft_d3;
  logic [2*DW-1:0] fft_d4;
  logic [2*DW-1:0] fft_d5;
  logic [2*DW-1:0] fft_d6;
  logic [2*DW-1:0] fft_d7;
  logic [2*DW-1:0] fft_d8;
  logic [2*DW-1:0] fft_d9;
  logic [2*DW-1:0] fft_d10;
  logic [2*DW-1:0] fft_d11;
  logic [2*DW-1:0] fft_d12;
  logic [2*DW-1:0] fft_d13;
  logic [2*DW-1:0] fft_d14;
  logic [2*DW-1:0] fft_d15;
  logic            done;
  logic [3:0]      freq;
  logic [2*DW-1:0] peak_mag;
  logic            overrun;

  modport master (
    output fft_valid,
    output fft_d0, fft_d1, fft_d2, fft_d3,
    output fft_d4, fft_d5, fft_d6, fft_d7,
    output fft_d8, fft_d9, fft_d10, fft_d11,
    output fft_d12, fft_d13, fft_d14, fft_d15,
    input  done, freq, peak_mag, overrun
  );

  modport slave (
    input  fft_valid,
    input  fft_d0, fft_d1, fft_d2, fft_d3,
    input  fft_d4, fft_d5, fft_d6, fft_d7,
    input  fft_d8, fft_d9, fft_d10, fft_d11,
    input  fft_d12, fft_d13, fft_d14, fft_d15,
    output done, freq, peak_mag, overrun
  );
endinterface

// File: rtl/fas_freq_analyzer.sv
// Dominant-bin finder: squared magnitude of each of 16 FFT bins,
// one bin per clock, strict-greater running max (lowest index wins).
module fas_freq_analyzer #(
  parameter int DW = 16
) (
  input logic       clk,
  input logic       rst,
  fas_freq_if.slave bus
);
  localparam int W = 2 * DW;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state;
  state_t         state_nx;
  logic [3:0]     cnt;
  logic [3:0]     run_idx;
  logic [3:0]     fin_idx;
  logic [W-1:0]   run_max;
  logic [W-1:0]   fin_max;
  logic [W-1:0]   mag_cur;
  logic [W-1:0]   mag_in0;
  logic           fin;
  logic           ovr;
  logic           gt;
  logic [W-1:0]   din [16];
  logic [W-1:0]   wr  [16];

  assign din[0]  = bus.fft_d0;
  assign din[1]  = bus.fft_d1;
  assign din[2]  = bus.fft_d2;
  assign din[3]  = bus.fft_d3;
  assign din[4]  = bus.fft_d4;
  assign din[5]  = bus.fft_d5;
  assign din[6]  = bus.fft_d6;
  assign din[7]  = bus.fft_d7;
  assign din[8]  = bus.fft_d8;
  assign din[9]  = bus.fft_d9;
  assign din[10] = bus.fft_d10;
  assign din[11] = bus.fft_d11;
  assign din[12] = bus.fft_d12;
  assign din[13] = bus.fft_d13;
  assign din[14] = bus.fft_d14;
  assign din[15] = bus.fft_d15;

  // Raw integer re^2+im^2; max 2^31 so W bits unsigned never overflows
  function automatic logic [W-1:0] mag(
    input logic [W-1:0] w
  );
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic signed [W-1:0]  pr;
    logic signed [W-1:0]  pim;
    re  = w[W-1:DW];
    im  = w[DW-1:0];
    pr  = re * re;
    pim = im * im;
    return $unsigned(pr) + $unsigned(pim);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (bus.fft_valid) begin
      state_nx = SCAN;
    end else if (state == SCAN && cnt == 4'd15) begin
      state_nx = IDLE;
    end
  end

  always_comb begin
    fin     = (state == SCAN) && (cnt == 4'd15);
    ovr     = (state == SCAN) && (cnt != 4'd15)
              && bus.fft_valid;
    mag_cur = mag(wr[cnt]);
    mag_in0 = mag(din[0]);
    gt      = mag_cur > run_max;
    fin_max = gt ? mag_cur : run_max;
    fin_idx = gt ? cnt : run_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      run_idx      <= '0;
      run_max      <= '0;
      bus.done     <= 1'b0;
      bus.overrun  <= 1'b0;
      bus.freq     <= '0;
      bus.peak_mag <= '0;
      for (int i = 0; i < 16; i++) begin
        wr[i] <= '0;
      end
    end else begin
      bus.done    <= fin;
      bus.overrun <= ovr;
      if (fin) begin
        bus.freq     <= fin_idx;
        bus.peak_mag <= fin_max;
      end
      // A new frame always wins over the scan in progress
      if (bus.fft_valid) begin
        for (int i = 0; i < 16; i++) begin
          wr[i] <= din[i];
        end
        run_max <= mag_in0;
        run_idx <= '0;
        cnt     <= 4'd1;
      end else if (state == SCAN) begin
        run_max <= fin_max;
        run_idx <= fin_idx;
        cnt     <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_fas_freq_analyzer.sv
// Scoreboard bench for fas_freq_analyzer: expected results are
// queued at frame capture and popped on each done pulse.
module tb_fas_freq_analyzer;
  typedef logic [31:0] frame_t [16];

  typedef struct {
    logic [3:0]  f;
    logic [31:0] p;
    int          c;
  } exp_t;

  logic   clk;
  logic   rst;
  int     cyc;
  int     total;
  int     bad;
  int     done_cnt;
  int     ovr_cnt;
  exp_t   q [$];
  frame_t fd;

  fas_freq_if #(.DW(16)) bus ();

  assign bus.fft_d0  = fd[0];
  assign bus.fft_d1  = fd[1];
  assign bus.fft_d2  = fd[2];
  assign bus.fft_d3  = fd[3];
  assign bus.fft_d4  = fd[4];
  assign bus.fft_d5  = fd[5];
  assign bus.fft_d6  = fd[6];
  assign bus.fft_d7  = fd[7];
  assign bus.fft_d8  = fd[8];
  assign bus.fft_d9  = fd[9];
  assign bus.fft_d10 = fd[10];
  assign bus.fft_d11 = fd[11];
  assign bus.fft_d12 = fd[12];
  assign bus.fft_d13 = fd[13];
  assign bus.fft_d14 = fd[14];
  assign bus.fft_d15 = fd[15];

  fas_freq_analyzer #(.DW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard: every done must match the oldest queued frame
  always @(negedge clk) begin
    if (bus.overrun === 1'b1) ovr_cnt = ovr_cnt + 1;
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      total = total + 1;
      if (q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_done cyc=%0d freq=%0d",
                 cyc, bus.freq);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.freq !== e.f || bus.peak_mag !== e.p
            || cyc !== e.c) begin
          bad = bad + 1;
          $display({"FAIL done_result got freq=%0d mag=%h ",
                    "cyc=%0d want freq=%0d mag=%h cyc=%0d"},
                   bus.freq, bus.peak_mag, cyc,
                   e.f, e.p, e.c);
        end
      end
    end
  end

  function automatic exp_t model(frame_t f, int c);
    exp_t      e;
    longint    best;
    longint    m;
    int        re;
    int        im;
    logic [15:0] h;
    best = -1;
    e.f  = 0;
    for (int k = 0; k < 16; k++) begin
      h  = f[k][31:16];
      re = int'($signed(h));
      h  = f[k][15:0];
      im = int'($signed(h));
      m  = longint'(re) * re + longint'(im) * im;
      if (m > best) begin
        best = m;
        e.f  = 4'(k);
      end
    end
    e.p = best[31:0];
    e.c = c + 15;
    return e;
  endfunction

  task automatic send(input frame_t f, output int c);
    @(negedge clk);
    fd            = f;
    bus.fft_valid = 1'b1;
    @(posedge clk);
    #1;
    c             = cyc;
    bus.fft_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
      #1;
    end
  endtask

  function automatic frame_t zero_frame();
    frame_t f;
    for (int k = 0; k < 16; k++) f[k] = 32'h0;
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total = total + 1;
      if (bus.done !== 1'b0 || bus.freq !== 4'd0
          || bus.peak_mag !== 32'd0
          || bus.overrun !== 1'b0) begin
        bad = bad + 1;
        $display("FAIL reset_outputs d=%b f=%0d m=%h o=%b",
                 bus.done, bus.freq, bus.peak_mag,
                 bus.overrun);
      end
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total = total + 1;
    if (done_cnt !== 0 || bus.freq !== 4'd0) begin
      bad = bad + 1;
      $display("FAIL idle_after_reset dones=%0d freq=%0d",
               done_cnt, bus.freq);
    end
  endtask

  task automatic test_single();
    frame_t f;
    exp_t   e;
    int     c;
    f    = zero_frame();
    f[5] = 32'h0300_0400;
    send(f, c);
    e.f = 4'd5;
    e.p = 32'h0019_0000;
    e.c = c + 15;
    q.push_back(e);
    wait_drain();
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL single_timeout pending=%0d want 0",
               q.size());
    end
  endtask

  task automatic test_extremes();
    frame_t f;
    exp_t   e;
    int     c;
    for (int k = 0; k < 16; k++)
      f[k] = (k % 2 == 0) ? 32'h0001_FFFF : 32'hFFFF_0001;
    f[2] = 32'h8000_8000;
    send(f, c);
    e.f = 4'd2;
    e.p = 32'h8000_0000;
    e.c = c + 15;
    q.push_back(e);
    wait_drain();
    f    = zero_frame();
    f[3] = 32'h0010_FFF0;
    f[9] = 32'h0010_FFF0;
    send(f, c);
    e.f = 4'd3;
    e.p = 32'd512;
    e.c = c + 15;
    q.push_back(e);
    wait_drain();
    f = zero_frame();
    send(f, c);
    e.f = 4'd0;
    e.p = 32'd0;
    e.c = c + 15;
    q.push_back(e);
    wait_drain();
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL extremes_timeout pending=%0d want 0",
               q.size());
    end
  endtask

  task automatic test_back_to_back(input int gap);
    frame_t fa;
    frame_t fb;
    exp_t   e;
    int     ca;
    int     cb;
    int     o0;
    o0     = ovr_cnt;
    fa     = zero_frame();
    fa[0]  = 32'h0100_0000;
    fb     = zero_frame();
    fb[15] = 32'h0000_0200;
    send(fa, ca);
    e.f = 4'd0;
    e.p = 32'h0001_0000;
    e.c = ca + 15;
    q.push_back(e);
    repeat (gap - 1) @(posedge clk);
    send(fb, cb);
    e.f = 4'd15;
    e.p = 32'h0004_0000;
    e.c = cb + 15;
    q.push_back(e);
    total = total + 1;
    if (cb - ca !== gap) begin
      bad = bad + 1;
      $display("FAIL b2b_spacing got %0d want %0d",
               cb - ca, gap);
    end
    wait_drain();
    total = total + 1;
    if (q.size() != 0 || ovr_cnt !== o0) begin
      bad = bad + 1;
      $display("FAIL b2b_gap%0d pending=%0d ovr=%0d want 0",
               gap, q.size(), ovr_cnt - o0);
    end
  endtask

  task automatic test_overrun();
    frame_t fa;
    frame_t fb;
    exp_t   e;
    int     ca;
    int     cb;
    int     o0;
    int     d0;
    o0    = ovr_cnt;
    fa    = zero_frame();
    fa[1] = 32'h0700_0000;
    fb    = zero_frame();
    fb[7] = 32'h0000_0500;
    send(fa, ca);
    e.f = 4'd1;
    e.p = 32'h0031_0000;
    e.c = ca + 15;
    q.push_back(e);
    repeat (4) @(posedge clk);
    send(fb, cb);
    void'(q.pop_back());
    d0 = done_cnt;
    total = total + 1;
    if (bus.overrun !== 1'b1) begin
      bad = bad + 1;
      $display("FAIL overrun_pulse got %b want 1",
               bus.overrun);
    end
    e.f = 4'd7;
    e.p = 32'h0019_0000;
    e.c = cb + 15;
    q.push_back(e);
    @(posedge clk);
    #1;
    total = total + 1;
    if (bus.overrun !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL overrun_width got %b want 0",
               bus.overrun);
    end
    wait_drain();
    total = total + 1;
    if (q.size() != 0 || ovr_cnt - o0 !== 1
        || done_cnt - d0 !== 1) begin
      bad = bad + 1;
      $display("FAIL overrun_frame pend=%0d ovr=%0d dn=%0d want 0 1 1",
               q.size(), ovr_cnt - o0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    frame_t f;
    exp_t   e;
    int     c;
    int     d0;
    f     = zero_frame();
    f[11] = 32'h0000_0900;
    send(f, c);
    q.push_back(model(f, c));
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b1;
    d0  = done_cnt;
    total = total + 1;
    if (bus.done !== 1'b0 || bus.freq !== 4'd0
        || bus.peak_mag !== 32'd0) begin
      bad = bad + 1;
      $display("FAIL reset_mid d=%b f=%0d m=%h want 0 0 0",
               bus.done, bus.freq, bus.peak_mag);
    end
    repeat (20) @(posedge clk);
    #1;
    total = total + 1;
    if (done_cnt !== d0 || bus.freq !== 4'd0) begin
      bad = bad + 1;
      $display("FAIL reset_mid_no_done dn=%0d f=%0d want 0 0",
               done_cnt - d0, bus.freq);
    end
    send(f, c);
    e.f = 4'd11;
    e.p = 32'h0051_0000;
    e.c = c + 15;
    q.push_back(e);
    wait_drain();
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL reset_mid_fresh pending=%0d want 0",
               q.size());
    end
  endtask

  task automatic test_random();
    frame_t f;
    int     c;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 16; k++) f[k] = $urandom;
      if (n == 5) f[13] = f[4];
      send(f, c);
      q.push_back(model(f, c));
      wait_drain();
      total = total + 1;
      if (q.size() != 0) begin
        bad = bad + 1;
        $display("FAIL random_%0d pending=%0d want 0",
                 n, q.size());
      end
    end
  endtask

  initial begin
    cyc           = 0;
    total         = 0;
    bad           = 0;
    done_cnt      = 0;
    ovr_cnt       = 0;
    rst           = 1'b0;
    bus.fft_valid = 1'b0;
    fd            = zero_frame();
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back(16);
    test_back_to_back(15);
    test_overrun();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL final_pending got %0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fas_freq_analyzer.md
Name: fas_freq_analyzer

Overview:
- Analysis stage directly downstream of the FAS FFT stage.
- Consumes each 16-point FFT frame, computes the squared magnitude of every bin and reports the index of the dominant bin on `freq`, with a one-cycle `done` strobe.
- Sustains one frame per 16 clocks, matching the FFT output rate.

Parameters:
- DW, 16: width of each real/imag component (signed 8.8 fixed point).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- fft_valid  input  1  one-cycle strobe; fft_d0..fft_d15 are valid this cycle.
- fft_d0 .. fft_d15  input  2*DW each  bin k: [31:16] real, [15:0] imag, two's complement.
- done  output  1  one-cycle pulse; freq/peak_mag are updated for the completed frame.
- freq  output  4  index (0..15) of the largest-magnitude bin of the last completed frame.
- peak_mag  output  2*DW  re^2+im^2 of that bin, unsigned, raw integer units.
- overrun  output  1  one-cycle pulse; an in-progress frame was abandoned.

Behaviour:
- Reset (rst==0 at posedge): done=0, freq=0, peak_mag=0, overrun=0, state=IDLE, bin counter=0, work registers cleared.
- States: IDLE, SCAN.
- Capture, edge E0 (fft_valid==1 sampled):
  - all 16 words are latched into the work register file;
  - mag(bin0) from the live inputs loads run_max, run_idx=0, cnt=1;
  - state goes to SCAN.
- SCAN, edges E1..E15: bin cnt is evaluated from the work registers.
  - If mag(cnt) > run_max (strictly greater), then run_max=mag and run_idx=cnt.
  - cnt then increments.
- Finalise at E15 (cnt==15):
  - comparison includes bin 15;
  - freq and peak_mag are written with the final winner;
  - done=1 for exactly the cycle E15..E16;
  - state goes to IDLE.
- Latency: done is high 15 cycles after the capturing edge.
- freq and peak_mag hold until the next finalise or reset.
- Magnitude arithmetic:
  - re*re and im*im are signed 16x16 products, each ≤ 2^30 (from -32768^2).
  - The sum is ≤ 2^31 and fits unsigned 32 bits with no saturation.
  - The sum is taken on raw integers; no fractional shift is applied.
- Ties: the lowest index wins, because the comparison is strict.
- All-zero frame: freq=0, peak_mag=0, done still pulses.
- fft_valid while in SCAN with cnt<15:
  - the current frame is abandoned and no done is issued for it;
  - overrun pulses for 1 cycle;
  - the new frame is captured exactly as at E0.
- fft_valid at the finalise edge (cnt==15):
  - the current frame finalises normally (done pulses);
  - the new frame is captured in the same edge (run_max/cnt reloaded);
  - no overrun.
  - This gives back-to-back operation at a 16-cycle frame period.
- fft_valid in IDLE: normal capture.
- Reset mid-SCAN: abort immediately, no done, all outputs return to reset values.
- Input words are sampled only on fft_valid edges; changes at other times have no effect.

Test Plan:
1. Reset: rst=0 for 3 cycles, then fft_valid low -> done=0, freq=0, peak_mag=0, overrun=0 throughout.
2. Single frame, bin5=32'h0300_0400, all others 0 -> done exactly 15 cycles after the fft_valid edge, freq=5, peak_mag=32'h0019_0000 (1638400).
3. Extremes and ties:
   - bin2=32'h8000_8000 with all others ±1 -> freq=2, peak_mag=32'h8000_0000.
   - Separate frame with bins 3 and 9 both 32'h0010_FFF0 and all others 0 -> freq=3.
4. Back-to-back: frame A (peak bin0=32'h0100_0000) at cycle 0, frame B (peak bin15=32'h0000_0200) at cycle 16 -> done at cycles 15 and 31, freq 0 then 15, peak_mag 0x10000 then 0x40000, overrun never asserted.
5. Overrun: frame A at cycle 0, frame B (peak bin7) at cycle 5 -> overrun high for cycle 5..6, no done at cycle 15, done at cycle 20 with freq=7.
6. Reset mid-op: frame at cycle 0, rst=0 at cycle 7 for 1 cycle -> no done pulse, freq/peak_mag = 0. A fresh frame afterwards completes in 15 cycles.
